// File: rtl/bin_a_bcd_4dig_pkg.sv
// Shared constants and state encoding for the 4-digit binary-to-BCD converter.
package bin_a_bcd_pkg;

    localparam int W_BIN   = 14;
    localparam int MAX_VAL = 9999;
    localparam int N_DIG   = 4;
    localparam int W_BCD   = 4 * N_DIG;
    localparam int W_CNT   = 4;

    localparam logic [W_BIN-1:0] MAX_BIN  = W_BIN'(MAX_VAL);
    localparam logic [W_CNT-1:0] CNT_ULT  = W_CNT'(W_BIN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } t_estado;

    // Clamp out-of-range inputs so the display always shows a legal 4-digit value.
    function automatic logic [W_BIN-1:0] f_satura(input logic [W_BIN-1:0] v);
        return (v > MAX_BIN) ? MAX_BIN : v;
    endfunction

endpackage

// File: rtl/bin_a_bcd_4dig_if.sv
// Request/result bundle between a value producer and the BCD converter.
interface bin_a_bcd_4dig_if;
    import bin_a_bcd_pkg::*;

    logic              i_Start;
    logic [W_BIN-1:0]  i_Bin;
    logic              o_Busy;
    logic              o_Done;
    logic              o_Ovf;
    logic [3:0]        o_Datos1;
    logic [3:0]        o_Datos2;
    logic [3:0]        o_Datos3;
    logic [3:0]        o_Datos4;

    modport master (
        output i_Start, i_Bin,
        input  o_Busy, o_Done, o_Ovf, o_Datos1, o_Datos2, o_Datos3, o_Datos4
    );

    modport slave (
        input  i_Start, i_Bin,
        output o_Busy, o_Done, o_Ovf, o_Datos1, o_Datos2, o_Datos3, o_Datos4
    );

endinterface

// File: rtl/bin_a_bcd_4dig_ajuste3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_ajuste3 (
    input  logic [3:0] i_Dig,
    output logic [3:0] o_Dig
);

    assign o_Dig = (i_Dig >= 4'd5) ? (i_Dig + 4'd3) : i_Dig;

endmodule

// File: rtl/bin_a_bcd_4dig.sv
// Iterative binary-to-BCD converter, one shift per clock, results held between runs.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | waiting for i_Start; last result held on the outputs
//  ST_SHIFT | W_BIN adjust-and-shift steps through the scratch register
//  ST_DONE  | publish scratch digits and overflow, pulse o_Done
module bin_a_bcd_4dig
    import bin_a_bcd_pkg::*;
(
    input  logic              i_Clk,
    input  logic              i_Rst,
    bin_a_bcd_4dig_if.slave   io_Bus
);

    t_estado            r_estado;
    t_estado            w_estado_sig;
    logic [W_CNT-1:0]   r_cnt;
    logic [W_BIN-1:0]   r_bin;
    logic [W_BCD-1:0]   r_bcd;
    logic [W_BCD-1:0]   r_datos;
    logic               r_ovf_cap;
    logic               r_ovf;
    logic               r_done;
    logic [W_BCD-1:0]   w_adj;
    logic               w_busy;
    logic               w_cargar;
    logic               w_desplazar;
    logic               w_publicar;

    // One correction cell per scratch digit, applied ahead of each shift.
    for (genvar g = 0; g < N_DIG; g++) begin : g_aj
        bcd_ajuste3 u_aj (
            .i_Dig (r_bcd[4*g +: 4]),
            .o_Dig (w_adj[4*g +: 4])
        );
    end

    // State register.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_estado <= ST_IDLE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_estado_sig = r_estado;
        w_busy       = 1'b0;
        w_cargar     = 1'b0;
        w_desplazar  = 1'b0;
        w_publicar   = 1'b0;
        case (r_estado)
            ST_IDLE: begin
                if (io_Bus.i_Start) begin
                    w_cargar     = 1'b1;
                    w_estado_sig = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_busy      = 1'b1;
                w_desplazar = 1'b1;
                if (r_cnt == CNT_ULT) begin
                    w_estado_sig = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy       = 1'b1;
                w_publicar   = 1'b1;
                w_estado_sig = ST_IDLE;
            end
            default: begin
                w_estado_sig = ST_IDLE;
            end
        endcase
    end

    // Capture, shift and publish; reset aborts a run without publishing.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_cnt     <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_datos   <= '0;
            r_ovf_cap <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_cargar) begin
                r_bin     <= f_satura(io_Bus.i_Bin);
                r_ovf_cap <= (io_Bus.i_Bin > MAX_BIN);
                r_bcd     <= '0;
                r_cnt     <= '0;
            end
            if (w_desplazar) begin
                {r_bcd, r_bin} <= {w_adj[W_BCD-2:0], r_bin, 1'b0};
                r_cnt          <= r_cnt + 1'b1;
            end
            if (w_publicar) begin
                r_datos <= r_bcd;
                r_ovf   <= r_ovf_cap;
                r_done  <= 1'b1;
            end
        end
    end

    assign io_Bus.o_Busy   = w_busy;
    assign io_Bus.o_Done   = r_done;
    assign io_Bus.o_Ovf    = r_ovf;
    assign io_Bus.o_Datos1 = r_datos[3:0];
    assign io_Bus.o_Datos2 = r_datos[7:4];
    assign io_Bus.o_Datos3 = r_datos[11:8];
    assign io_Bus.o_Datos4 = r_datos[15:12];

endmodule

// File: tb/tb_bin_a_bcd_4dig.sv
// Scoreboard bench for bin_a_bcd_4dig: stimulus pushes expected results, a monitor checks them.
module tb_bin_a_bcd_4dig;

    typedef struct {
        int v;
        int d4, d3, d2, d1;
        bit ovf;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t sbq[$];

    bin_a_bcd_4dig_if bus ();

    bin_a_bcd_4dig dut (
        .i_Clk  (clk),
        .i_Rst  (rst),
        .io_Bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits of the clamped value, plain arithmetic.
    function automatic exp_t model(input int v, input int done_cyc);
        exp_t e;
        int   s;
        s      = (v > 9999) ? 9999 : v;
        e.v    = v;
        e.d1   = s % 10;
        e.d2   = (s / 10) % 10;
        e.d3   = (s / 100) % 10;
        e.d4   = s / 1000;
        e.ovf  = (v > 9999);
        e.cyc  = done_cyc;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.o_Busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        if (bus.o_Busy !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: o_Busy=%b still high after %0d cycles, required 0", bus.o_Busy, n);
        end
    endtask

    // Issue one start pulse; the accept edge is the next posedge.
    task automatic issue(input int v, input bit expect_done);
        wait_idle();
        bus.i_Start = 1'b1;
        bus.i_Bin   = 14'(v);
        if (expect_done) sbq.push_back(model(v, cyc + 1 + 15));
        tick();
        bus.i_Start = 1'b0;
        bus.i_Bin   = 14'($urandom_range(16383));
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (bus.o_Busy !== 1'b0 || bus.o_Done !== 1'b0 || bus.o_Ovf !== 1'b0 ||
            {bus.o_Datos4, bus.o_Datos3, bus.o_Datos2, bus.o_Datos1} !== 16'h0000) begin
            n_err++;
            $display("FAIL %s: busy=%b done=%b ovf=%b digits=%h, required all 0",
                     name, bus.o_Busy, bus.o_Done, bus.o_Ovf,
                     {bus.o_Datos4, bus.o_Datos3, bus.o_Datos2, bus.o_Datos1});
        end
    endtask

    // Monitor: scoreboard pops on o_Done, plus hold and busy-length checks every cycle.
    logic       last_rst = 1'b1;
    logic [15:0] prev_dig = '0;
    logic       prev_ovf  = 1'b0;
    int         run       = 0;

    always begin
        logic       rst_at_edge;
        logic [15:0] dig;
        exp_t       e;
        @(negedge clk);
        rst_at_edge = last_rst;
        last_rst    = rst;
        dig = {bus.o_Datos4, bus.o_Datos3, bus.o_Datos2, bus.o_Datos1};

        if (rst_at_edge) begin
            run = 0;
        end else if (bus.o_Busy === 1'b1) begin
            run++;
        end else if (run != 0) begin
            n_cmp++;
            if (run != 15) begin
                n_err++;
                $display("FAIL busy_len: o_Busy high %0d cycles, required 15", run);
            end
            run = 0;
        end

        if (!rst_at_edge && bus.o_Done !== 1'b1) begin
            n_cmp++;
            if (dig !== prev_dig || bus.o_Ovf !== prev_ovf) begin
                n_err++;
                $display("FAIL hold: digits=%h ovf=%b changed without o_Done, required %h ovf=%b",
                         dig, bus.o_Ovf, prev_dig, prev_ovf);
            end
        end

        if (bus.o_Done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: o_Done at cycle %0d digits=%h, required no pulse", cyc, dig);
            end else begin
                e = sbq.pop_front();
                n_cmp++;
                if (dig !== {4'(e.d4), 4'(e.d3), 4'(e.d2), 4'(e.d1)}) begin
                    n_err++;
                    $display("FAIL digits(%0d): got %h, required %0d%0d%0d%0d",
                             e.v, dig, e.d4, e.d3, e.d2, e.d1);
                end
                n_cmp++;
                if (bus.o_Ovf !== e.ovf) begin
                    n_err++;
                    $display("FAIL ovf(%0d): got %b, required %b", e.v, bus.o_Ovf, e.ovf);
                end
                n_cmp++;
                if (cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL latency(%0d): o_Done at cycle %0d, required %0d", e.v, cyc, e.cyc);
                end
                n_cmp++;
                if (bus.o_Busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_at_done(%0d): o_Busy=%b, required 0", e.v, bus.o_Busy);
                end
            end
        end
        prev_dig = dig;
        prev_ovf = bus.o_Ovf;
    end

    initial begin
        int c0;
        int v;
        int r;
        n_cmp = 0;
        n_err = 0;
        rst         = 1'b1;
        bus.i_Start = 1'b1;
        bus.i_Bin   = 14'd1579;

        // Reset held two clocks with start asserted: must stay idle and zero.
        tick();
        check_zero("reset_1");
        tick();
        check_zero("reset_2");
        rst         = 1'b0;
        bus.i_Start = 1'b0;
        tick();
        check_zero("after_reset");

        issue(1579, 1'b1);
        issue(0, 1'b1);
        issue(9999, 1'b1);
        issue(10000, 1'b1);
        issue(16383, 1'b1);

        // Extra start and changed input mid-conversion are ignored.
        issue(2468, 1'b1);
        repeat (5) tick();
        bus.i_Start = 1'b1;
        bus.i_Bin   = 14'd333;
        tick();
        bus.i_Start = 1'b0;

        // Reset seven clocks into a conversion: no result, outputs cleared.
        issue(4321, 1'b0);
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("abort_reset");
        issue(42, 1'b1);

        // Start held high: second value accepted 16 clocks after the first.
        wait_idle();
        bus.i_Start = 1'b1;
        bus.i_Bin   = 14'd1234;
        c0 = cyc + 1;
        sbq.push_back(model(1234, c0 + 15));
        sbq.push_back(model(8765, c0 + 31));
        tick();
        bus.i_Bin = 14'd8765;
        repeat (16) tick();
        bus.i_Start = 1'b0;

        // Randomized values with idle gaps.
        for (int k = 0; k < 2000; k++) begin
            r = int'($urandom_range(99));
            if (r < 70)      v = int'($urandom_range(9999));
            else if (r < 90) v = int'($urandom_range(16383, 10000));
            else begin
                case ($urandom_range(5))
                    0: v = 0;
                    1: v = 9;
                    2: v = 9999;
                    3: v = 10000;
                    4: v = 16383;
                    default: v = 8191;
                endcase
            end
            issue(v, 1'b1);
            repeat ($urandom_range(3)) tick();
        end

        for (int n = 0; n < 100 && sbq.size() != 0; n++) tick();
        repeat (3) tick();
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, required 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
